// File: rtl/icu_tag_seq.sv
`default_nettype none
// ============================================================================
// Module   : icu_tag_seq
// Purpose  : I-cache tag array sequencer: fetch lookup, miss line-fill request
//            and full invalidate sweep on flush (and on reset when
//            ICU_TAG_SWEEP_ON_RESET_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module icu_tag_seq #(
    parameter int TAG_W = 18,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             fetch_req,
    input  logic [TAG_W-1:0] fetch_tag,
    input  logic [IDX_W-1:0] fetch_idx,
    output logic             fetch_rdy,
    output logic             lkup_done,
    output logic             lkup_hit,
    output logic             fill_req,
    output logic [TAG_W-1:0] fill_tag,
    output logic [IDX_W-1:0] fill_idx,
    input  logic             fill_ack,
    input  logic             fill_done,
    input  logic             fill_err,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic [TAG_W-1:0] icu_tag_in,
    output logic             icu_tag_vld,
    output logic             icu_tag_we,
    output logic [IDX_W-1:0] icu_tag_addr,
    output logic             icu_tag_enable,
    input  logic             itag_hit
);

    typedef enum logic [2:0] {
        SWEEP = 3'd0,
        IDLE  = 3'd1,
        CMP   = 3'd2,
        FREQ  = 3'd3,
        FWAIT = 3'd4,
        WRITE = 3'd5
    } state_t;

`ifdef ICU_TAG_SWEEP_ON_RESET_EN
    localparam state_t c_rst_state = SWEEP;
    localparam logic   c_rst_busy  = 1'b1;
`else
    localparam state_t c_rst_state = IDLE;
    localparam logic   c_rst_busy  = 1'b0;
`endif
    localparam logic [IDX_W-1:0] c_idx_last = '1;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_pend;
    logic             w_fetch_acc;
    logic             w_flush_any;
    logic             w_fill_end;

    // A flush in IDLE always beats a simultaneous fetch.
    assign w_fetch_acc = (r_state == IDLE) && fetch_req && !flush_req;
    assign w_flush_any = r_pend || flush_req;
    assign w_fill_end  = fill_done && ((r_state == FWAIT) || ((r_state == FREQ) && fill_ack));

    always_comb begin
        w_next = r_state;
        case (r_state)
            SWEEP: if ((r_cnt == c_idx_last) && !flush_req) w_next = IDLE;
            IDLE:  if (flush_req) w_next = SWEEP;
                   else if (fetch_req) w_next = CMP;
            CMP:   if (!itag_hit) w_next = FREQ;
                   else w_next = w_flush_any ? SWEEP : IDLE;
            FREQ:  if (fill_ack) w_next = FWAIT;
            FWAIT: w_next = FWAIT;
            WRITE: w_next = w_flush_any ? SWEEP : IDLE;
            default: w_next = c_rst_state;
        endcase
        // Covers both FWAIT and an ack+done collapsed into one FREQ cycle.
        if (w_fill_end) w_next = fill_err ? (w_flush_any ? SWEEP : IDLE) : WRITE;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state    <= c_rst_state;
            r_cnt      <= '0;
            r_tag      <= '0;
            r_idx      <= '0;
            r_pend     <= 1'b0;
            fetch_rdy  <= (c_rst_state == IDLE);
            lkup_done  <= 1'b0;
            lkup_hit   <= 1'b0;
            fill_req   <= 1'b0;
            flush_busy <= c_rst_busy;
        end else begin
            r_state    <= w_next;
            fetch_rdy  <= (w_next == IDLE);
            fill_req   <= (w_next == FREQ);
            lkup_done  <= (r_state == CMP);
            flush_busy <= (w_next == SWEEP) || w_flush_any;
            if (r_state == CMP) lkup_hit <= itag_hit;
            if (w_fetch_acc) begin
                r_tag <= fetch_tag;
                r_idx <= fetch_idx;
            end
            if (w_next == SWEEP) r_pend <= 1'b0;
            else if (flush_req)  r_pend <= 1'b1;
            // Counter idles at 0 so every sweep starts from the first index.
            if ((r_state != SWEEP) || flush_req || (r_cnt == c_idx_last)) r_cnt <= '0;
            else r_cnt <= r_cnt + 1'b1;
        end
    end

    assign fill_tag = r_tag;
    assign fill_idx = r_idx;

    // Tag array port is forced quiet while reset is asserted.
    always_comb begin
        icu_tag_in     = '0;
        icu_tag_addr   = '0;
        icu_tag_vld    = 1'b0;
        icu_tag_we     = 1'b0;
        icu_tag_enable = 1'b0;
        if (reset_l) begin
            case (r_state)
                IDLE: if (w_fetch_acc) begin
                    icu_tag_in     = fetch_tag;
                    icu_tag_addr   = fetch_idx;
                    icu_tag_vld    = 1'b1;
                    icu_tag_enable = 1'b1;
                end
                WRITE: begin
                    icu_tag_in     = r_tag;
                    icu_tag_addr   = r_idx;
                    icu_tag_vld    = 1'b1;
                    icu_tag_we     = 1'b1;
                    icu_tag_enable = 1'b1;
                end
                SWEEP: begin
                    icu_tag_addr   = r_cnt;
                    icu_tag_we     = 1'b1;
                    icu_tag_enable = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icu_tag_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_icu_tag_seq
// Purpose  : Scoreboard bench for icu_tag_seq with a behavioural tag array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icu_tag_seq;
    localparam int TAG_W = 18;
    localparam int IDX_W = 10;
    localparam int DEPTH = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             reset_l = 1'b0;
    logic             fetch_req = 1'b0;
    logic [TAG_W-1:0] fetch_tag = '0;
    logic [IDX_W-1:0] fetch_idx = '0;
    logic             fetch_rdy, lkup_done, lkup_hit, fill_req, flush_busy;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;
    logic             fill_ack = 1'b0;
    logic             fill_done = 1'b0;
    logic             fill_err = 1'b0;
    logic             flush_req = 1'b0;
    logic [TAG_W-1:0] icu_tag_in;
    logic             icu_tag_vld, icu_tag_we, icu_tag_enable;
    logic [IDX_W-1:0] icu_tag_addr;
    logic             itag_hit = 1'b0;

    icu_tag_seq #(.TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset_l(reset_l),
        .fetch_req(fetch_req), .fetch_tag(fetch_tag), .fetch_idx(fetch_idx),
        .fetch_rdy(fetch_rdy), .lkup_done(lkup_done), .lkup_hit(lkup_hit),
        .fill_req(fill_req), .fill_tag(fill_tag), .fill_idx(fill_idx),
        .fill_ack(fill_ack), .fill_done(fill_done), .fill_err(fill_err),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .icu_tag_in(icu_tag_in), .icu_tag_vld(icu_tag_vld), .icu_tag_we(icu_tag_we),
        .icu_tag_addr(icu_tag_addr), .icu_tag_enable(icu_tag_enable),
        .itag_hit(itag_hit)
    );

    always #5 clk = ~clk;

    // Tag array: unwritten entries look like valid tag 0x2A5, so a missed sweep write shows up.
    logic [TAG_W:0]   r_mem [DEPTH];
    logic [DEPTH-1:0] r_written = '0;
    always @(posedge clk) begin
        if (icu_tag_enable) begin
            if (icu_tag_we) begin
                r_mem[icu_tag_addr]     <= {icu_tag_vld, icu_tag_in};
                r_written[icu_tag_addr] <= 1'b1;
            end else if (r_written[icu_tag_addr]) begin
                itag_hit <= r_mem[icu_tag_addr][TAG_W] && (r_mem[icu_tag_addr][TAG_W-1:0] == icu_tag_in);
            end else begin
                itag_hit <= (icu_tag_in == 18'h2A5);
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit                     q_lkup [$];
    logic [TAG_W+IDX_W-1:0] q_fill [$];
    logic [IDX_W+TAG_W-1:0] q_wr   [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result, fill request or tag write.
    logic [IDX_W-1:0]       sweep_next = '0;
    int                     n_sweep_wr = 0;
    logic                   prev_fill = 1'b0;
    logic [TAG_W+IDX_W-1:0] cur_fill = '0;
    always @(negedge clk) begin
        if (reset_l) begin
            if (lkup_done) begin
                if (q_lkup.size() == 0) check("lkup_done_unexpected", lkup_done, 0);
                else check("lkup_hit", lkup_hit, q_lkup.pop_front());
            end
            if (fill_req) begin
                if (!prev_fill) begin
                    if (q_fill.size() == 0) check("fill_req_unexpected", fill_req, 0);
                    else cur_fill = q_fill.pop_front();
                end
                check("fill_tag_idx", {fill_tag, fill_idx}, cur_fill);
            end
            if (icu_tag_enable && icu_tag_we) begin
                if (!icu_tag_vld) begin
                    check("sweep_write", {icu_tag_addr, icu_tag_in}, {sweep_next, TAG_W'(0)});
                    sweep_next = sweep_next + 1'b1;
                    n_sweep_wr++;
                end else if (q_wr.size() == 0) begin
                    check("tag_we_unexpected", icu_tag_we, 0);
                end else begin
                    check("fill_write", {icu_tag_addr, icu_tag_in}, q_wr.pop_front());
                end
            end
        end
        prev_fill = fill_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE #1 after an edge; returns in the cycle lkup_done is high.
    task automatic lookup(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i, input bit hit);
        check("fetch_rdy_idle", fetch_rdy, 1);
        fetch_req = 1'b1;
        fetch_tag = t;
        fetch_idx = i;
        q_lkup.push_back(hit);
        if (!hit) q_fill.push_back({t, i});
        step();
        fetch_req = 1'b0;
        step();
    endtask

    task automatic wait_fill();
        int k = 0;
        while (!fill_req && k < 20) begin
            step();
            k++;
        end
        check("fill_req_seen", fill_req, 1);
    endtask

    task automatic wait_sweep(output int n_busy, output int n_rdy);
        n_busy = 0;
        n_rdy  = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!flush_busy) break;
            n_busy++;
            if (fetch_rdy) n_rdy++;
        end
        check("sweep_terminates", flush_busy, 0);
        step();
    endtask

    initial begin
        int nb, nr, sw0;
        repeat (3) @(posedge clk);
        #1;
`ifdef ICU_TAG_SWEEP_ON_RESET_EN
        check("rst_fetch_rdy", fetch_rdy, 0);
        check("rst_flush_busy", flush_busy, 1);
`else
        check("rst_fetch_rdy", fetch_rdy, 1);
        check("rst_flush_busy", flush_busy, 0);
`endif
        check("rst_lkup", {lkup_done, lkup_hit}, 0);
        check("rst_fill", {fill_req, fill_tag, fill_idx}, 0);
        check("rst_tag_port", {icu_tag_we, icu_tag_vld, icu_tag_enable, icu_tag_in, icu_tag_addr}, 0);
        reset_l = 1'b1;
        sw0 = n_sweep_wr;
`ifndef ICU_TAG_SWEEP_ON_RESET_EN
        // Flush and fetch together in IDLE: flush wins.
        flush_req = 1'b1;
        fetch_req = 1'b1;
        fetch_tag = 18'h111;
        fetch_idx = 10'h005;
        step();
        flush_req = 1'b0;
        fetch_req = 1'b0;
        check("flush_busy_set", flush_busy, 1);
        check("flush_fetch_rdy_low", fetch_rdy, 0);
`endif
        wait_sweep(nb, nr);
        check("sweep_busy_cycles", nb, 1024);
        check("sweep_fetch_rdy_low", nr, 0);
        check("sweep_write_count", n_sweep_wr - sw0, 1024);

        // Miss, fill with ack after 3 cycles and done 5 later, then hits.
        lookup(18'h2A5, 10'h013, 1'b0);
        wait_fill();
        repeat (3) step();
        fill_ack = 1'b1;
        step();
        fill_ack = 1'b0;
        repeat (4) step();
        fill_done = 1'b1;
        q_wr.push_back({10'h013, 18'h2A5});
        step();
        fill_done = 1'b0;
        check("write_cycle_we", icu_tag_we, 1);
        step();
        lookup(18'h2A5, 10'h013, 1'b1);
        lookup(18'h2A5, 10'h013, 1'b1);
        lookup(18'h2A6, 10'h013, 1'b0);

        // Ack and failing done in the same cycle: no tag write.
        wait_fill();
        step();
        fill_ack  = 1'b1;
        fill_done = 1'b1;
        fill_err  = 1'b1;
        step();
        {fill_ack, fill_done, fill_err} = 3'b000;
        lookup(18'h2A6, 10'h013, 1'b0);

        // Flush while waiting for the fill: write completes, then full sweep.
        wait_fill();
        fill_ack = 1'b1;
        step();
        fill_ack  = 1'b0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        check("pending_flush_busy", flush_busy, 1);
        check("pending_fetch_rdy", fetch_rdy, 0);
        fill_done = 1'b1;
        q_wr.push_back({10'h013, 18'h2A6});
        sw0 = n_sweep_wr;
        step();
        fill_done = 1'b0;
        wait_sweep(nb, nr);
        check("flush_sweep_write_count", n_sweep_wr - sw0, 1024);
        check("flush_sweep_fetch_rdy_low", nr, 0);
        lookup(18'h2A6, 10'h013, 1'b0);
        wait_fill();
        fill_ack  = 1'b1;
        fill_done = 1'b1;
        fill_err  = 1'b1;
        step();
        {fill_ack, fill_done, fill_err} = 3'b000;
        repeat (3) step();

        check("lkup_queue_drained", q_lkup.size(), 0);
        check("fill_queue_drained", q_fill.size(), 0);
        check("write_queue_drained", q_wr.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/icu_tag_seq.md
# icu_tag_seq

Sequencer driving the instruction-cache tag array write/lookup port (`icu_tag_*`, `enable`) and consuming its `itag_hit` result. It runs three jobs: the fetch lookup handshake, the miss line-fill request to the bus interface, and the invalidate sweep over all tag entries on reset or flush. It sits between fetch/ICU control and the tag array, directly upstream of the tag array.

## Interface
- `TAG_W`, default 18: tag address width. Equals `it_msb+1`.
- `IDX_W`, default 10: line index width. Corresponds to `ic_msb:4`.
- `clk` in 1: clock.
- `reset_l` in 1: asynchronous, active-low reset.
- `fetch_req` in 1: lookup request.
- `fetch_tag` in TAG_W: tag of the fetch address.
- `fetch_idx` in IDX_W: line index of the fetch address.
- `fetch_rdy` out 1: lookup can be accepted this cycle.
- `lkup_done` out 1: one-cycle pulse; lookup result valid.
- `lkup_hit` out 1: hit flag. Qualified by `lkup_done`.
- `fill_req` out 1: line fill request to the bus interface.
- `fill_tag`, `fill_idx` out TAG_W / IDX_W: line to fill.
- `fill_ack` in 1: bus interface accepted `fill_req`.
- `fill_done` in 1: fill finished.
- `fill_err` in 1: fill failed. Qualified by `fill_done`.
- `flush_req` in 1: request to invalidate the whole cache. Single-cycle pulse.
- `flush_busy` out 1: sweep in progress or pending.
- `icu_tag_in` out TAG_W, `icu_tag_vld` out 1, `icu_tag_we` out 1, `icu_tag_addr` out IDX_W, `icu_tag_enable` out 1: drive the tag array.
- `itag_hit` in 1: compare result from the tag array.

## Operation
- States: SWEEP, IDLE, CMP, FREQ, FWAIT, WRITE.
- **IDLE**
  - `fetch_rdy`=1.
  - On `fetch_req`, drive `icu_tag_addr`=`fetch_idx`, `icu_tag_in`=`fetch_tag`, `icu_tag_vld`=1, `icu_tag_we`=0, `icu_tag_enable`=1, and latch tag/idx. Go to CMP.
  - With no request, `icu_tag_enable`=0 (power-down).
- **CMP**
  - Sample `itag_hit` at the end of the cycle.
  - Next cycle: `lkup_done`=1 and `lkup_hit`=sampled value.
  - Hit → IDLE. Miss → FREQ.
- **FREQ**
  - `fill_req`=1 with the latched tag/idx, held stable until `fill_ack`.
  - On `fill_ack` → FWAIT. If `fill_done` arrives in the same cycle, act as FWAIT.
- **FWAIT**
  - Wait for `fill_done`.
  - `fill_err`=1 → IDLE with no tag write; the entry stays as it was.
  - Otherwise → WRITE.
- **WRITE**
  - One cycle: `icu_tag_we`=1, `icu_tag_vld`=1, `icu_tag_addr`=idx, `icu_tag_in`=tag, `icu_tag_enable`=1.
  - Then → IDLE, or SWEEP if a flush is pending.
- **SWEEP**
  - A counter walks idx 0 … 2^IDX_W−1, one per cycle, with `icu_tag_we`=1, `icu_tag_vld`=0, `icu_tag_in`=0, `icu_tag_enable`=1.
  - After the last index → IDLE.
  - `fetch_rdy`=0 throughout.
- Flush handling:
  - `flush_req` in IDLE (including a simultaneous `fetch_req`): flush wins; the fetch is not accepted.
  - `flush_req` in CMP/FREQ/FWAIT/WRITE: set a pending flag; SWEEP starts once the fill sequence returns toward IDLE.
  - `flush_req` during SWEEP: restarts the counter at 0.
- `flush_busy` = pending flag OR state==SWEEP.

## Timing
- Reset values: state SWEEP (see Configuration), counter 0, `fetch_rdy`=0, `lkup_done`=0, `lkup_hit`=0, `fill_req`=0, `fill_tag`/`fill_idx`=0, `icu_tag_we`=0, `icu_tag_vld`=0, `icu_tag_in`=0, `icu_tag_addr`=0, `icu_tag_enable`=0, `flush_busy`=1.
- `icu_tag_*` outputs are combinational from state and latched data. The tag array registers them at the next edge.
- Lookup latency: accepted at edge N; `lkup_done` high in the cycle after edge N+1. Throughput is one lookup per 2 cycles.
- A fill write in cycle W is completed by the tag array before any lookup accepted at W+1 is compared, so a same-index hit is guaranteed.
- A sweep takes exactly 2^IDX_W cycles. Pending flush to SWEEP entry takes 1 cycle after WRITE/FWAIT exit.
- Reset asserted mid-operation: all state is abandoned immediately. `fill_req` drops asynchronously, and the bus interface must discard any outstanding fill.

## Configuration
- `ICU_TAG_SWEEP_ON_RESET_EN`
  - Defined: reset state is SWEEP, so all tags are invalidated after reset. `flush_busy`=1 and `fetch_rdy`=0 from reset.
  - Undefined: reset state is IDLE with `fetch_rdy`=1 and `flush_busy`=0. Tags are initialised by BIST/software flush.

## Test plan
- Reset with macro on, IDX_W=10: `flush_busy` high for exactly 1024 cycles, every index written with vld=0, then `fetch_rdy`=1.
- Lookup tag 0x2A5, idx 0x013 after sweep → `lkup_done` with `lkup_hit`=0 two cycles later, then `fill_req` with tag 0x2A5 / idx 0x013.
- `fill_ack` after 3 cycles, `fill_done` after 5 more → one WRITE cycle. A lookup of tag 0x2A5 / idx 0x013 issued next cycle → `lkup_hit`=1. Tag 0x2A6, same idx → `lkup_hit`=0.
- `fill_done` with `fill_err`=1 → no `icu_tag_we` pulse. A repeated lookup of the same tag/idx misses and re-requests the fill.
- `flush_req` during FWAIT → `flush_busy`=1, fill write completes, then a 1024-cycle sweep. The previously filled line now misses.
- `flush_req` and `fetch_req` in the same IDLE cycle → fetch not accepted, SWEEP entered, `fetch_rdy`=0 until the sweep ends.
